dmem_param: RTL and testbench

//  Parametrised single-port data memory with a valid/ready request port, byte-write strobes,

---
 rtl/dmem_param.sv | 159 +++++++++++++++
 tb/tb_dmem_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_param.sv
// Purpose : parametrised single-port data memory, valid/ready request port, byte strobes, error flag.
// Latency : 1 cycle (acceptance edge = commit edge); WAIT_CYCLES+2 edges with DMEM_WAIT_EN.
// Backpr. : READY high outside reset; with DMEM_WAIT_EN READY drops from acceptance until the response.
//
// Optional feature macro: DMEM_WAIT_EN -- adds a wait-state FSM (IDLE/WAIT/RESP) and a cycle
// counter that models slow memory. Undefined: plain 1-cycle memory.
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RST            synchronous active-high reset (array contents are not reset)
//   REQ / READY    request handshake, transfer when both are high at a rising edge
//   ADDR           byte address, word index = ADDR[AW+OB-1:OB]
//   RW             0 = read, 1 = write
//   BE             per-byte write enables (ignored on reads)
//   WD             write data
//   RVALID         one-cycle response pulse, one per accepted request, in order
//   RD             read data (0 for writes and rejected accesses), holds while RVALID=0
//   ERR            access rejected (out of range or misaligned), qualified by RVALID
module dmem_param #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ,
    output logic                READY,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic                RW,
    input  logic [DATA_W/8-1:0] BE,
    input  logic [DATA_W-1:0]   WD,
    output logic                RVALID,
    output logic [DATA_W-1:0]   RD,
    output logic                ERR
);

    localparam int NB    = DATA_W / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int OB    = $clog2(NB);
    localparam int ABITS = AW + OB;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [NB-1:0]     be;
        logic [DATA_W-1:0] wd;
    } req_t;

    logic [DATA_W-1:0] mem [DEPTH];

    req_t          req_in;   // request as presented on the port
    req_t          c_req;    // request being committed this cycle
    logic          c_en;     // this rising edge is a commit edge
    logic [AW-1:0] c_idx;
    logic          aligned;
    logic          in_range;
    logic          legal;

    always_comb begin
        req_in      = '0;
        req_in.addr = ADDR;
        req_in.rw   = RW;
        req_in.be   = BE;
        req_in.wd   = WD;
    end

`ifdef DMEM_WAIT_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state;
    logic [7:0] cnt;
    req_t       lat_req;

    // Reset has priority over every transition, so an access in WAIT/RESP is simply dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            lat_req <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (REQ) begin
                        lat_req <= req_in;
                        cnt     <= 8'(WAIT_CYCLES);
                        state   <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 8'd1;
                    // Leave on the edge where the counter reaches zero.
                    if (cnt == 8'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign READY = !RST && (state == ST_IDLE);
    assign c_en  = !RST && (state == ST_RESP);
    assign c_req = lat_req;
`else
    assign READY = !RST;
    assign c_en  = REQ && READY;
    assign c_req = req_in;
`endif

    // Legality of the committed access; the generate guards keep the slices well-formed
    // for single-byte words and for address buses no wider than the array.
    generate
        if (OB > 0) begin : g_align
            assign aligned = (c_req.addr[OB-1:0] == '0);
        end else begin : g_no_align
            assign aligned = 1'b1;
        end
        if (ADDR_W > ABITS) begin : g_range
            assign in_range = (c_req.addr[ADDR_W-1:ABITS] == '0);
        end else begin : g_full_range
            assign in_range = 1'b1;
        end
    endgenerate

    assign legal = aligned && in_range;
    assign c_idx = c_req.addr[ABITS-1:OB];

    // Array write: not reset; rejected accesses leave it untouched.
    always_ff @(posedge CLK) begin
        if (c_en && legal && c_req.rw) begin
            for (int i = 0; i < NB; i++) begin
                if (c_req.be[i]) begin
                    mem[c_idx][8*i +: 8] <= c_req.wd[8*i +: 8];
                end
            end
        end
    end

    // Response registers. The read samples the array before this edge's write lands,
    // so there is no same-edge forwarding.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RVALID <= 1'b0;
            RD     <= '0;
            ERR    <= 1'b0;
        end else begin
            RVALID <= c_en;
            ERR    <= c_en && !legal;
            if (c_en) begin
                RD <= (legal && !c_req.rw) ? mem[c_idx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_param.sv
module tb_dmem_param;

    localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_EN
    localparam int EXP_LAT = WAIT_CYCLES + 2;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ;
    logic        READY;
    logic [31:0] ADDR;
    logic        RW;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic        RVALID;
    logic [31:0] RD;
    logic        ERR;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [1024];

    dmem_param #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .READY(READY), .ADDR(ADDR), .RW(RW),
        .BE(BE), .WD(WD), .RVALID(RVALID), .RD(RD), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog");
    end

    // Reference: a word is legal when it lies in the 4 KiB window and is word aligned.
    function automatic bit legal(input logic [31:0] a);
        return (a < 32'h1000) && (a % 4 == 0);
    endfunction

    task automatic model(input logic [31:0] a, input logic rw, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] erd, output logic eerr);
        logic [31:0] w;
        eerr = !legal(a);
        erd  = '0;
        if (!eerr) begin
            w = ref_mem[a / 4];
            if (rw) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
                ref_mem[a / 4] = w;
            end else begin
                erd = w;
            end
        end
    endtask

    // Drives one request, waits for its response, and reports what came back.
    // Request inputs are scrambled right after acceptance.
    task automatic issue(input logic [31:0] a, input logic rw, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat, output logic idle_ok);
        int n;
        @(negedge CLK);
        REQ = 1'b1; ADDR = a; RW = rw; BE = be; WD = wd;
        n = 0;
        while (READY !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        REQ = 1'b0; ADDR = $urandom; RW = 1'($urandom); BE = 4'($urandom); WD = $urandom;
        lat = 1;
        while (RVALID !== 1'b1 && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        rd  = RD;
        err = ERR;
        @(negedge CLK);
        idle_ok = (RVALID === 1'b0) && (ERR === 1'b0) && (RD === rd);
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = 1'b1; ADDR = '0; RW = 1'b1; BE = 4'hF; WD = 32'h1234_5678;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({READY, RVALID, ERR} !== 3'b000 || RD !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: READY=%b RVALID=%b ERR=%b RD=%h, want 0 0 0 0",
                     READY, RVALID, ERR, RD);
        end
        REQ = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if (READY !== 1'b1 || RVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: READY=%b RVALID=%b, want 1 0", READY, RVALID);
        end
    endtask

    // Initialise words 0..31 so every later read has a defined expected value.
    task automatic test_fill();
        logic [31:0] rd, erd, wd;
        logic err, eerr, ok;
        int lat;
        for (int w = 0; w < 32; w++) begin
            wd = $urandom;
            model(32'(w * 4), 1'b1, 4'hF, wd, erd, eerr);
            issue(32'(w * 4), 1'b1, 4'hF, wd, rd, err, lat, ok);
            vectors++;
            if (rd !== erd || err !== eerr || lat !== EXP_LAT || ok !== 1'b1) begin
                miscompares++;
                $display("FAIL fill[%0d]: rd=%h err=%b lat=%0d idle=%b, want %h %b %0d 1",
                         w, rd, err, lat, ok, erd, eerr, EXP_LAT);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] t_addr [9] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10,
                                    32'h1000, 32'h12, 32'h0, 32'h10};
        logic        t_rw   [9] = '{1, 0, 1, 1, 0, 1, 1, 0, 0};
        logic [3:0]  t_be   [9] = '{4'hF, 4'h0, 4'h1, 4'h4, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
        logic [31:0] t_wd   [9] = '{32'hDEADBEEF, 32'h0, 32'h000000AA, 32'h00CC0000, 32'h0,
                                    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic [31:0] rd, erd;
        logic err, eerr, ok;
        int lat;
        for (int k = 0; k < 9; k++) begin
            model(t_addr[k], t_rw[k], t_be[k], t_wd[k], erd, eerr);
            issue(t_addr[k], t_rw[k], t_be[k], t_wd[k], rd, err, lat, ok);
            vectors++;
            if (rd !== erd || err !== eerr || lat !== EXP_LAT || ok !== 1'b1) begin
                miscompares++;
                $display("FAIL directed[%0d]: rd=%h err=%b lat=%0d idle=%b, want %h %b %0d 1",
                         k, rd, err, lat, ok, erd, eerr, EXP_LAT);
            end
            if (k == 1 || k == 4 || k == 8) begin
                vectors++;
                if (rd !== ((k == 1) ? 32'hDEADBEEF : 32'hDECCBEAA)) begin
                    miscompares++;
                    $display("FAIL directed_value[%0d]: rd=%h, want %h", k, rd,
                             (k == 1) ? 32'hDEADBEEF : 32'hDECCBEAA);
                end
            end
            if (k == 5 || k == 6) begin
                vectors++;
                if (err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL directed_err[%0d]: err=%b, want 1", k, err);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, erd;
        logic [3:0]  be;
        logic        rw, err, eerr, ok;
        int lat, kind;
        for (int k = 0; k < 250; k++) begin
            kind = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 31) * 4);
            if (kind == 8) a = a | 32'($urandom_range(1, 3));
            if (kind == 9) a = $urandom | 32'h1000;
            rw = 1'($urandom);
            be = 4'($urandom);
            wd = $urandom;
            model(a, rw, be, wd, erd, eerr);
            issue(a, rw, be, wd, rd, err, lat, ok);
            vectors++;
            if (rd !== erd || err !== eerr || lat !== EXP_LAT || ok !== 1'b1) begin
                miscompares++;
                $display("FAIL random[%0d] a=%h rw=%b be=%h: rd=%h err=%b lat=%0d idle=%b, want %h %b %0d 1",
                         k, a, rw, be, rd, err, lat, ok, erd, eerr, EXP_LAT);
            end
        end
    endtask

`ifndef DMEM_WAIT_EN
    // Four reads with REQ held high: responses arrive on consecutive cycles.
    task automatic test_back_to_back();
        logic [31:0] exp_rd [4];
        logic        eerr;
        for (int k = 0; k < 4; k++) model(32'(k * 4), 1'b0, 4'h0, 32'h0, exp_rd[k], eerr);
        for (int k = 0; k <= 5; k++) begin
            @(negedge CLK);
            if (k >= 1 && k <= 4) begin
                vectors++;
                if (RVALID !== 1'b1 || RD !== exp_rd[k-1] || ERR !== 1'b0 || READY !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b[%0d]: RVALID=%b RD=%h ERR=%b READY=%b, want 1 %h 0 1",
                             k - 1, RVALID, RD, ERR, READY, exp_rd[k-1]);
                end
            end
            if (k == 5) begin
                vectors++;
                if (RVALID !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_end: RVALID=%b, want 0", RVALID);
                end
            end
            REQ = (k < 4); ADDR = 32'(k * 4); RW = 1'b0; BE = 4'($urandom); WD = $urandom;
        end
        REQ = 1'b0;
    endtask
`else
    // Read 0x10 while scrambling the request inputs; watch READY/RVALID cycle by cycle.
    task automatic test_wait();
        logic [31:0] erd;
        logic        eerr;
        model(32'h10, 1'b0, 4'h0, 32'h0, erd, eerr);
        @(negedge CLK);
        REQ = 1'b1; ADDR = 32'h10; RW = 1'b0; BE = 4'h0; WD = 32'h0;
        vectors++;
        if (READY !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_ready_idle: READY=%b, want 1", READY);
        end
        for (int n = 1; n <= EXP_LAT; n++) begin
            @(negedge CLK);
            vectors++;
            if (READY !== (n == EXP_LAT) || RVALID !== (n == EXP_LAT)) begin
                miscompares++;
                $display("FAIL wait_cycle[%0d]: READY=%b RVALID=%b, want %b %b",
                         n, READY, RVALID, n == EXP_LAT, n == EXP_LAT);
            end
            REQ = (n < EXP_LAT - 1) ? 1'($urandom) : 1'b0;
            ADDR = $urandom; RW = 1'($urandom); BE = 4'($urandom); WD = $urandom;
        end
        vectors++;
        if (RD !== erd || ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_data: RD=%h ERR=%b, want %h 0", RD, ERR, erd);
        end
        @(negedge CLK);
    endtask

    // Write 0x55 to 0x20, reset during WAIT: the write must vanish without a response.
    task automatic test_reset_mid();
        logic [31:0] rd, erd;
        logic err, eerr, ok, seen;
        int lat;
        @(negedge CLK);
        REQ = 1'b1; ADDR = 32'h20; RW = 1'b1; BE = 4'hF; WD = 32'h55;
        @(negedge CLK);
        REQ = 1'b0; RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if (READY !== 1'b1 || RVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_release: READY=%b RVALID=%b, want 1 0", READY, RVALID);
        end
        seen = 1'b0;
        repeat (EXP_LAT + 2) begin
            @(negedge CLK);
            if (RVALID === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_no_resp: RVALID seen=%b, want 0", seen);
        end
        model(32'h20, 1'b0, 4'h0, 32'h0, erd, eerr);
        issue(32'h20, 1'b0, 4'h0, 32'h0, rd, err, lat, ok);
        vectors++;
        if (rd !== erd || err !== 1'b0 || lat !== EXP_LAT) begin
            miscompares++;
            $display("FAIL rstmid_read: rd=%h err=%b lat=%0d, want %h 0 %0d",
                     rd, err, lat, erd, EXP_LAT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_directed();
`ifndef DMEM_WAIT_EN
        test_back_to_back();
`else
        test_wait();
        test_reset_mid();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
